instr_fetch_unit: RTL and testbench

//  Fetch stage upstream of the single-cycle ARM datapath. Owns the fetch PC and issues

---
 rtl/instr_fetch_unit_pkg.sv | 19 +
 rtl/instr_fetch_unit_fetch_fifo.sv | 79 +++++++
 rtl/instr_fetch_unit.sv | 114 +++++++++++
 tb/tb_instr_fetch_unit.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// rtl/instr_fetch_unit_pkg.sv - shared types and constants for the instruction fetch stage
package instr_fetch_unit_pkg;

   localparam int          WORD_W     = 32;
   localparam logic [31:0] PC_STEP    = 32'd4;
   localparam logic [31:0] PC8_OFFSET = 32'd8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_DROP = 2'd2
   } fetch_state_e;

   typedef struct packed {
      logic [WORD_W-1:0] pc;
      logic [WORD_W-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_unit_fetch_fifo.sv
// rtl/instr_fetch_unit_fetch_fifo.sv - prefetch FIFO of {pc, instr} entries with flush
module fetch_fifo
   import instr_fetch_unit_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  fetch_entry_t             wr_entry,
   output fetch_entry_t             rd_entry,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int AW    = $clog2(DEPTH);
   localparam int CNT_W = AW + 1;

   fetch_entry_t     mem_q [DEPTH];
   fetch_entry_t     mem_d [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push, do_pop;

   assign full     = (count_q == CNT_W'(DEPTH));
   assign empty    = (count_q == '0);
   assign count    = count_q;
   assign rd_entry = mem_q[rd_ptr_q];

   // The fetch FSM never pushes into a full FIFO unless a pop frees the slot.
   assign do_push = push & (~full | pop);
   assign do_pop  = pop & ~empty;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) begin
            mem_d[wr_ptr_q] = wr_entry;
            wr_ptr_d        = wr_ptr_q + AW'(1);
         end
         if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - fetch PC, single-outstanding instruction memory reads, prefetch to decode
module instr_fetch_unit
   import instr_fetch_unit_pkg::*;
#(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        REDIRECT,
   input  logic [31:0] REDIRECT_PC,
   output logic        MEM_REQ,
   output logic [31:0] MEM_ADDR,
   input  logic        MEM_ACK,
   input  logic [31:0] MEM_RDATA,
   output logic        INSTR_VALID,
   input  logic        INSTR_READY,
   output logic [31:0] INSTR,
   output logic [31:0] INSTR_PC,
   output logic [31:0] INSTR_PC8
);

   localparam int CNT_W = $clog2(DEPTH) + 1;

   fetch_state_e     state_q, state_d;
   logic [31:0]      pc_q, pc_d;
   logic [31:0]      drop_addr_q, drop_addr_d;
   logic [31:0]      redirect_pc;
   logic             push, pop;
   logic [CNT_W-1:0] count;
   logic             full, empty;
   fetch_entry_t     head;

   assign redirect_pc = REDIRECT_PC & 32'hFFFF_FFFC;
   assign pop         = INSTR_VALID & INSTR_READY & ~REDIRECT;

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      drop_addr_d = drop_addr_q;
      push        = 1'b0;
      MEM_REQ     = (state_q != ST_IDLE);
      // While draining a stale request the address must stay on the old word.
      MEM_ADDR    = (state_q == ST_DROP) ? drop_addr_q : pc_q;
      case (state_q)
         ST_IDLE: begin
            if (REDIRECT) begin
               pc_d = redirect_pc;
            end else if (!full) begin
               state_d = ST_REQ;
            end
         end
         ST_REQ: begin
            if (MEM_ACK) begin
               if (REDIRECT) begin
                  pc_d = redirect_pc;
               end else begin
                  push = 1'b1;
                  pc_d = pc_q + PC_STEP;
                  if (!((count < CNT_W'(DEPTH - 1)) || pop)) begin
                     state_d = ST_IDLE;
                  end
               end
            end else if (REDIRECT) begin
               pc_d        = redirect_pc;
               drop_addr_d = pc_q;
               state_d     = ST_DROP;
            end
         end
         ST_DROP: begin
            if (REDIRECT) begin
               pc_d = redirect_pc;
            end
            if (MEM_ACK) begin
               state_d = ST_REQ;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q     <= ST_IDLE;
         pc_q        <= RESET_PC;
         drop_addr_q <= '0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         drop_addr_q <= drop_addr_d;
      end
   end

   fetch_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk      (CLK),
      .rst_n    (RST_N),
      .push     (push),
      .pop      (pop),
      .flush    (REDIRECT),
      .wr_entry ('{pc: pc_q, instr: MEM_RDATA}),
      .rd_entry (head),
      .count    (count),
      .full     (full),
      .empty    (empty)
   );

   assign INSTR_VALID = ~empty;
   assign INSTR       = head.instr;
   assign INSTR_PC    = head.pc;
   assign INSTR_PC8   = head.pc + PC8_OFFSET;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - randomized and directed bench for instr_fetch_unit
module tb_instr_fetch_unit;

   localparam int DEPTH = 4;

   logic        CLK = 1'b0;
   logic        RST_N = 1'b0;
   logic        REDIRECT = 1'b0;
   logic [31:0] REDIRECT_PC = '0;
   logic        MEM_REQ;
   logic [31:0] MEM_ADDR;
   logic        MEM_ACK = 1'b0;
   logic [31:0] MEM_RDATA = '0;
   logic        INSTR_VALID;
   logic        INSTR_READY = 1'b0;
   logic [31:0] INSTR;
   logic [31:0] INSTR_PC;
   logic [31:0] INSTR_PC8;

   instr_fetch_unit #(
      .DEPTH    (DEPTH),
      .RESET_PC (32'h0000_0000)
   ) dut (
      .CLK         (CLK),
      .RST_N       (RST_N),
      .REDIRECT    (REDIRECT),
      .REDIRECT_PC (REDIRECT_PC),
      .MEM_REQ     (MEM_REQ),
      .MEM_ADDR    (MEM_ADDR),
      .MEM_ACK     (MEM_ACK),
      .MEM_RDATA   (MEM_RDATA),
      .INSTR_VALID (INSTR_VALID),
      .INSTR_READY (INSTR_READY),
      .INSTR       (INSTR),
      .INSTR_PC    (INSTR_PC),
      .INSTR_PC8   (INSTR_PC8)
   );

   always #5 CLK = ~CLK;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference: prefetched words as {pc, instr}; one outstanding read, possibly stale.
   logic [63:0] mq[$];
   logic [31:0] m_pc;
   logic [31:0] m_addr;
   bit          m_out;
   bit          m_stale;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_pc    = 32'h0;
      m_addr  = 32'h0;
      m_out   = 1'b0;
      m_stale = 1'b0;
   endtask

   task automatic model_step(input bit rd, input logic [31:0] rpc, input bit ack,
                             input bit rdy, input logic [31:0] rdata);
      int          n_pre;
      bit          popped;
      logic [31:0] tgt;
      tgt    = rpc & 32'hFFFF_FFFC;
      n_pre  = mq.size();
      popped = (n_pre > 0) && rdy && !rd;
      if (rd) mq.delete();
      else if (popped) void'(mq.pop_front());
      if (m_out && ack) begin
         if (rd) begin
            m_pc    = tgt;
            m_addr  = tgt;
            m_stale = 1'b0;
         end else if (m_stale) begin
            m_stale = 1'b0;
            m_addr  = m_pc;
         end else begin
            mq.push_back({m_pc, rdata});
            m_pc = m_pc + 32'd4;
            if (mq.size() < DEPTH) m_addr = m_pc;
            else m_out = 1'b0;
         end
      end else if (m_out) begin
         if (rd) begin
            m_pc    = tgt;
            m_stale = 1'b1;
         end
      end else begin
         if (rd) m_pc = tgt;
         else if (n_pre < DEPTH) begin
            m_out  = 1'b1;
            m_addr = m_pc;
         end
      end
   endtask

   task automatic compare();
      chk("mem_req", 32'(MEM_REQ), 32'(m_out));
      if (m_out) chk("mem_addr", MEM_ADDR, m_addr);
      chk("instr_valid", 32'(INSTR_VALID), 32'(mq.size() > 0));
      if (mq.size() > 0) begin
         chk("instr", INSTR, mq[0][31:0]);
         chk("instr_pc", INSTR_PC, mq[0][63:32]);
         chk("instr_pc8", INSTR_PC8, mq[0][63:32] + 32'd8);
      end
   endtask

   task automatic cycle(input bit rd, input logic [31:0] rpc, input bit ack, input bit rdy);
      logic [31:0] rdata;
      rdata       = $urandom;
      REDIRECT    = rd;
      REDIRECT_PC = rpc;
      MEM_ACK     = ack;
      MEM_RDATA   = rdata;
      INSTR_READY = rdy;
      @(posedge CLK);
      model_step(rd, rpc, ack, rdy, rdata);
      #1;
      compare();
   endtask

   task automatic do_reset();
      RST_N       = 1'b0;
      REDIRECT    = 1'b0;
      MEM_ACK     = 1'b0;
      INSTR_READY = 1'b0;
      model_reset();
      #2;
      chk("rst_mem_req", 32'(MEM_REQ), 32'h0);
      chk("rst_valid", 32'(INSTR_VALID), 32'h0);
      chk("rst_instr", INSTR, 32'h0);
      chk("rst_instr_pc", INSTR_PC, 32'h0);
      chk("rst_instr_pc8", INSTR_PC8, 32'h8);
      @(posedge CLK);
      #1;
      RST_N = 1'b1;
   endtask

   initial begin
      int          nreq;
      logic [31:0] lit;
      @(posedge CLK);
      #1;
      do_reset();

      // Zero-latency memory, decode always ready: sequential PCs back-to-back.
      lit = 32'h0;
      for (int i = 0; i < 10; i++) begin
         cycle(1'b0, 32'h0, 1'b1, 1'b1);
         chk("a_valid", 32'(INSTR_VALID), 32'(i >= 1));
         if (INSTR_VALID) begin
            chk("a_pc", INSTR_PC, lit);
            chk("a_pc8", INSTR_PC8, lit + 32'd8);
            lit = lit + 32'd4;
         end
      end

      // Decode stalled: exactly DEPTH reads, then drain in order.
      do_reset();
      nreq = 0;
      for (int i = 0; i < 12; i++) begin
         if (MEM_REQ) nreq++;
         cycle(1'b0, 32'h0, 1'b1, 1'b0);
      end
      chk("b_reqs", 32'(nreq), 32'd4);
      chk("b_mem_req_off", 32'(MEM_REQ), 32'h0);
      chk("b_model_count", 32'(mq.size()), 32'd4);
      for (int i = 0; i < 4; i++) begin
         chk("b_drain_pc", INSTR_PC, 32'(i * 4));
         cycle(1'b0, 32'h0, 1'b0, 1'b1);
      end

      // Redirect during a 3-cycle read: stale word dropped, refetch at target.
      do_reset();
      cycle(1'b0, 32'h0, 1'b0, 1'b0);
      chk("c_req", 32'(MEM_REQ), 32'h1);
      cycle(1'b1, 32'h100, 1'b0, 1'b0);
      chk("c_hold_addr", MEM_ADDR, 32'h0);
      chk("c_hold_req", 32'(MEM_REQ), 32'h1);
      cycle(1'b0, 32'h0, 1'b0, 1'b0);
      cycle(1'b0, 32'h0, 1'b1, 1'b0);
      chk("c_new_addr", MEM_ADDR, 32'h100);
      chk("c_no_valid", 32'(INSTR_VALID), 32'h0);
      cycle(1'b0, 32'h0, 1'b1, 1'b0);
      chk("c_first_pc", INSTR_PC, 32'h100);

      // Redirect coincident with an ACK while two words are buffered.
      do_reset();
      cycle(1'b0, 32'h0, 1'b1, 1'b0);
      cycle(1'b0, 32'h0, 1'b1, 1'b0);
      cycle(1'b0, 32'h0, 1'b1, 1'b0);
      chk("d_model_count", 32'(mq.size()), 32'd2);
      cycle(1'b1, 32'h200, 1'b1, 1'b0);
      chk("d_flushed", 32'(INSTR_VALID), 32'h0);
      chk("d_addr", MEM_ADDR, 32'h200);
      cycle(1'b0, 32'h0, 1'b1, 1'b0);
      chk("d_pc", INSTR_PC, 32'h200);

      // Asynchronous reset in the middle of a request.
      do_reset();
      cycle(1'b0, 32'h0, 1'b0, 1'b0);
      chk("e_req", 32'(MEM_REQ), 32'h1);
      do_reset();
      cycle(1'b0, 32'h0, 1'b0, 1'b0);
      chk("e_refetch", MEM_ADDR, 32'h0);

      // Wrap at the top of the address space; low target bits ignored.
      cycle(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);
      cycle(1'b0, 32'h0, 1'b1, 1'b0);
      chk("f_addr_top", MEM_ADDR, 32'hFFFF_FFFC);
      cycle(1'b0, 32'h0, 1'b1, 1'b0);
      chk("f_addr_wrap", MEM_ADDR, 32'h0);
      chk("f_pc", INSTR_PC, 32'hFFFF_FFFC);
      chk("f_pc8", INSTR_PC8, 32'h4);

      // Random traffic against the reference.
      for (int i = 0; i < 3000; i++) begin
         cycle($urandom_range(0, 99) < 4, $urandom, $urandom_range(0, 99) < 45,
               $urandom_range(0, 99) < 60);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
